// File: rtl/output_layer_acc_pkg.sv
// Shared widths, FSM encoding and sign-magnitude conversion helpers.
package output_layer_acc_pkg;

    localparam int unsigned BIT   = 16;
    localparam int unsigned W_BIT = 8;
    localparam int unsigned N_CLS = 10;

    // Largest magnitude a BIT-wide sign-magnitude code can carry.
    localparam longint SM_MAG_MAX = (longint'(1) <<< (BIT - 1)) - 1;
    // Saturated-max code; argmax ranks it above every ordinary value.
    localparam logic [BIT-1:0] SM_SAT_MAX = {1'b1, {(BIT - 1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_ACT,
        ST_MAC,
        ST_CONV
    } state_e;

    // Sign-magnitude to two's complement; -0 maps to 0.
    function automatic logic signed [BIT:0] sm_to_tc(input logic [BIT-1:0] sm);
        logic signed [BIT:0] mag;
        mag = $signed({2'b00, sm[BIT-2:0]});
        return sm[BIT-1] ? -mag : mag;
    endfunction

    // Two's complement to sign-magnitude with saturation; zero is always +0.
    function automatic logic [BIT-1:0] tc_to_sm_sat(input longint v);
        if (v > SM_MAG_MAX) begin
            return SM_SAT_MAX;
        end
        if (v < -SM_MAG_MAX) begin
            return {BIT{1'b1}};
        end
        if (v < 0) begin
            return {1'b1, (BIT - 1)'(-v)};
        end
        return {1'b0, (BIT - 1)'(v)};
    endfunction

endpackage

// File: rtl/output_layer_acc_sm_mul_shift.sv
// Sign-magnitude multiply, magnitude truncated by FRAC, signed result (zero is +0).
module output_layer_acc_sm_mul_shift #(
    parameter int unsigned A_W  = 16,
    parameter int unsigned B_W  = 8,
    parameter int unsigned FRAC = 7
) (
    input  logic [A_W-1:0]             a_i,
    input  logic [B_W-1:0]             b_i,
    output logic signed [A_W+B_W-2:0]  prod_c_o
);

    localparam int unsigned MAG_W = A_W + B_W - 2;

    logic [MAG_W-1:0] full_mag;
    logic [MAG_W-1:0] shr_mag;
    logic             neg;

    // Multiply magnitudes, drop fraction bits, then apply the product sign.
    always_comb begin
        full_mag = MAG_W'(a_i[A_W-2:0]) * MAG_W'(b_i[B_W-2:0]);
        shr_mag  = full_mag >> FRAC;
        neg      = a_i[A_W-1] ^ b_i[B_W-1];
        prod_c_o = '0;
        if (shr_mag != '0) begin
            prod_c_o = neg ? -$signed({1'b0, shr_mag}) : $signed({1'b0, shr_mag});
        end
    end

endmodule

// File: rtl/output_layer_acc.sv
// Final dense layer: accumulates 10 class scores over N_IN streamed activations.
module output_layer_acc
    import output_layer_acc_pkg::*;
#(
    parameter int unsigned N_IN = 64,
    parameter int unsigned FRAC = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    input  logic [BIT-1:0]             act_in,
    input  logic                       act_valid,
    output logic                       act_ready,
    output logic [$clog2(N_IN)-1:0]    w_addr,
    input  logic [N_CLS*W_BIT-1:0]     w_data,
    input  logic [N_CLS*BIT-1:0]       bias_in,
    output logic [N_CLS*BIT-1:0]       scores_out,
    output logic                       scores_valid,
    output logic                       done
);

    localparam int unsigned CNT_W = $clog2(N_IN);
    localparam int unsigned ACC_W = BIT + W_BIT + CNT_W + 1;
    localparam int unsigned P_W   = BIT + W_BIT - 1;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [CNT_W-1:0]          w_addr_q, w_addr_d;
    logic [BIT-1:0]            act_q, act_d;
    logic signed [ACC_W-1:0]   acc_q [N_CLS];
    logic signed [ACC_W-1:0]   acc_d [N_CLS];
    logic [N_CLS*BIT-1:0]      scores_q, scores_d;
    logic                      scores_valid_q, scores_valid_d;
    logic                      done_q, done_d;
    logic                      busy_q, busy_d;
    logic                      act_ready_q, act_ready_d;
    logic signed [P_W-1:0]     prod_c [N_CLS];

    // One scaled product per class from the latched activation and its ROM weight.
    for (genvar g = 0; g < N_CLS; g++) begin : g_mul
        output_layer_acc_sm_mul_shift #(
            .A_W  (BIT),
            .B_W  (W_BIT),
            .FRAC (FRAC)
        ) u_mul (
            .a_i      (act_q),
            .b_i      (w_data[g*W_BIT +: W_BIT]),
            .prod_c_o (prod_c[g])
        );
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        w_addr_d       = w_addr_q;
        act_d          = act_q;
        acc_d          = acc_q;
        scores_d       = scores_q;
        scores_valid_d = scores_valid_q;
        done_d         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d        = ST_LOAD;
                    scores_valid_d = 1'b0;
                end
            end
            ST_LOAD: begin
                for (int c = 0; c < N_CLS; c++) begin
                    acc_d[c] = ACC_W'(sm_to_tc(bias_in[c*BIT +: BIT]));
                end
                count_d  = '0;
                w_addr_d = '0;
                state_d  = ST_WAIT_ACT;
            end
            ST_WAIT_ACT: begin
                if (act_valid) begin
                    act_d   = act_in;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                for (int c = 0; c < N_CLS; c++) begin
                    acc_d[c] = acc_q[c] + ACC_W'(prod_c[c]);
                end
                count_d  = count_q + CNT_W'(1);
                w_addr_d = count_q + CNT_W'(1);
                state_d  = (count_q == CNT_W'(N_IN - 1)) ? ST_CONV : ST_WAIT_ACT;
            end
            ST_CONV: begin
                // Slot order is reversed so argmax reports 9 - class.
                for (int c = 0; c < N_CLS; c++) begin
                    scores_d[(N_CLS-1-c)*BIT +: BIT] = tc_to_sm_sat(longint'(acc_q[c]));
                end
                done_d         = 1'b1;
                scores_valid_d = 1'b1;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = (state_d != ST_IDLE);
        act_ready_d = (state_d == ST_WAIT_ACT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            w_addr_q       <= '0;
            act_q          <= '0;
            scores_q       <= '0;
            scores_valid_q <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            act_ready_q    <= 1'b0;
            for (int c = 0; c < N_CLS; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            w_addr_q       <= w_addr_d;
            act_q          <= act_d;
            scores_q       <= scores_d;
            scores_valid_q <= scores_valid_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
            act_ready_q    <= act_ready_d;
            for (int c = 0; c < N_CLS; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

    assign busy         = busy_q;
    assign act_ready    = act_ready_q;
    assign w_addr       = w_addr_q;
    assign scores_out   = scores_q;
    assign scores_valid = scores_valid_q;
    assign done         = done_q;

endmodule
